// File: rtl/sm_divider_pkg.sv
// Shared types and helpers for the sign-magnitude arithmetic datapath.
// Holds the divider state encoding and the negative-zero normaliser.
package sm_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Generic up to 64 bits: n is the word width, bit n-1 is the sign.
    function automatic logic [63:0] sm_normalize(
        input logic [63:0] w,
        input int unsigned n
    );
        logic [63:0] mmask;
        mmask = (64'd1 << (n - 1)) - 64'd1;
        if ((w & mmask) == 64'd0)
            return 64'd0;
        return w;
    endfunction

endpackage

// File: rtl/sm_divider_if.sv
// Operand and result handshake bundle for the sign-magnitude divider.
// master drives operands and accepts results; slave is the divider.
interface sm_divider_if #(
    parameter int N = 4
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/sm_div_step.sv
// One combinational restoring-division iteration on M magnitude bits.
// Shifts {rem, sreg} left, trial-subtracts the divisor, shifts in q bit.
module sm_div_step #(
    parameter int M = 3
) (
    input  logic [M-1:0] i_rem,
    input  logic [M-1:0] i_sreg,
    input  logic [M-1:0] i_dvs,
    output logic [M-1:0] o_rem,
    output logic [M-1:0] o_sreg,
    output logic         o_qbit
);
    logic [M:0]   w_rem_sh;
    logic [M+1:0] w_diff;
    logic         w_borrow;

    assign w_rem_sh = {i_rem, i_sreg[M-1]};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, i_dvs};
    assign w_borrow = w_diff[M+1];
    assign o_qbit   = ~w_borrow;
    // The kept value is always below the divisor, so it fits in M bits.
    assign o_rem    = M'(w_borrow ? {1'b0, w_rem_sh} : w_diff);
    assign o_sreg   = M'({i_sreg, o_qbit});
endmodule

// File: rtl/sm_divider.sv
// Multi-cycle sign-magnitude restoring divider, one quotient bit per clock.
// FSM and iteration counter live here; the datapath step is sm_div_step.
module sm_divider
    import sm_divider_pkg::*;
#(
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sm_divider_if.slave bus
);
    localparam int M  = N - 1;
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_CALC = CALC;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [M-1:0]  r_rem;
    logic [M-1:0]  r_sreg;
    logic [M-1:0]  r_dvs;
    logic          r_sa;
    logic          r_sb;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_r;
    logic          r_dz;
    logic          r_ovalid;

    logic [M-1:0]  w_nrem;
    logic [M-1:0]  w_nsreg;
    logic          w_qbit;
    logic [M-1:0]  w_qmag;
    logic [M-1:0]  w_amag;
    logic [M-1:0]  w_bmag;

    assign w_amag = bus.a[M-1:0];
    assign w_bmag = bus.b[M-1:0];
    assign w_qmag = M'({w_nsreg >> 1, w_qbit});

    sm_div_step #(.M(M)) u_step (
        .i_rem  (r_rem),
        .i_sreg (r_sreg),
        .i_dvs  (r_dvs),
        .o_rem  (w_nrem),
        .o_sreg (w_nsreg),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_sreg   <= '0;
            r_dvs    <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_q      <= '0;
            r_r      <= '0;
            r_dz     <= 1'b0;
            r_ovalid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sa    <= bus.a[N-1];
                        r_sb    <= bus.b[N-1];
                        r_sreg  <= w_amag;
                        r_dvs   <= w_bmag;
                        r_rem   <= '0;
                        r_cnt   <= CW'(N - 2);
                        r_state <= (w_bmag == '0) ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem  <= w_nrem;
                    r_sreg <= w_nsreg;
                    if (r_cnt == '0) begin
                        r_q      <= N'(sm_normalize(64'({r_sa ^ r_sb, w_qmag}), N));
                        r_r      <= N'(sm_normalize(64'({r_sa, w_nrem}), N));
                        r_dz     <= 1'b0;
                        r_ovalid <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    // Divide-by-zero enters here unpublished; results land one edge later.
                    if (!r_ovalid) begin
                        r_q      <= {r_sa ^ r_sb, {M{1'b1}}};
                        r_r      <= N'(sm_normalize(64'({r_sa, r_sreg}), N));
                        r_dz     <= 1'b1;
                        r_ovalid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_ovalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = r_ovalid;
    assign bus.quotient    = r_q;
    assign bus.remainder   = r_r;
    assign bus.div_by_zero = r_dz;
endmodule

// File: tb/tb_sm_divider.sv
// Directed and exhaustive bench for the N=4 sign-magnitude divider.
// Expected values come from hand tables and a / % reference model.
module tb_sm_divider;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    sm_divider_if #(.N(4)) bus ();

    sm_divider #(.N(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] ia, input logic [3:0] ib,
                         output logic [3:0] oq, output logic [3:0] orr,
                         output logic odz, output int olat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = ia;
        bus.b         = ib;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        olat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                olat = k;
                break;
            end
        end
        oq  = bus.quotient;
        orr = bus.remainder;
        odz = bus.div_by_zero;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    function automatic logic [8:0] ref_div(input logic [3:0] ia,
                                           input logic [3:0] ib);
        int ma, mb, qm, rm;
        logic qs, rs;
        ma = int'(ia[2:0]);
        mb = int'(ib[2:0]);
        if (mb == 0) begin
            qm = 7;
            qs = ia[3] ^ ib[3];
            rm = ma;
            rs = (ma == 0) ? 1'b0 : ia[3];
            return {1'b1, qs, qm[2:0], rs, rm[2:0]};
        end
        qm = ma / mb;
        rm = ma % mb;
        qs = (qm == 0) ? 1'b0 : (ia[3] ^ ib[3]);
        rs = (rm == 0) ? 1'b0 : ia[3];
        return {1'b0, qs, qm[2:0], rs, rm[2:0]};
    endfunction

    vec_t       tbl [10];
    logic [3:0] q, r;
    logic       dz;
    int         lat;
    logic [8:0] exp9;

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        tbl[0] = '{4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 3};
        tbl[1] = '{4'b1111, 4'b0010, 4'b1011, 4'b1001, 1'b0, 3};
        tbl[2] = '{4'b0011, 4'b1101, 4'b0000, 4'b0011, 1'b0, 3};
        tbl[3] = '{4'b1101, 4'b1000, 4'b0111, 4'b1101, 1'b1, 1};
        tbl[4] = '{4'b0110, 4'b0011, 4'b0010, 4'b0000, 1'b0, 3};
        tbl[5] = '{4'b1000, 4'b0101, 4'b0000, 4'b0000, 1'b0, 3};
        tbl[6] = '{4'b0111, 4'b0001, 4'b0111, 4'b0000, 1'b0, 3};
        tbl[7] = '{4'b1110, 4'b1011, 4'b0010, 4'b0000, 1'b0, 3};
        tbl[8] = '{4'b0101, 4'b1011, 4'b1001, 4'b0010, 1'b0, 3};
        tbl[9] = '{4'b1000, 4'b1000, 4'b0111, 4'b0000, 1'b1, 1};

        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 16'(bus.in_ready), 16'h1);
        chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
        chk("rst_q_r_dz", 16'({bus.quotient, bus.remainder, bus.div_by_zero}), 16'h0);
        #20;
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].a, tbl[i].b, q, r, dz, lat);
            chk($sformatf("tbl%0d_lat", i), 16'(lat), 16'(tbl[i].lat));
            chk($sformatf("tbl%0d_q", i), 16'(q), 16'(tbl[i].q));
            chk($sformatf("tbl%0d_r", i), 16'(r), 16'(tbl[i].r));
            chk($sformatf("tbl%0d_dz", i), 16'(dz), 16'(tbl[i].dz));
        end

        // Backpressure: hold result, ignore new operands.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 4'b0110;
        bus.b = 4'b0011;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        chk("bp_lat", 16'(lat), 16'd3);
        bus.in_valid = 1'b1;
        bus.a = 4'b0111;
        bus.b = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold", 16'({bus.out_valid, bus.in_ready, bus.quotient,
                                bus.remainder, bus.div_by_zero}),
                16'({1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0}));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_no_turnaround", 16'(bus.in_ready), 16'h0);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk("bp_release", 16'({bus.out_valid, bus.in_ready}), 16'b01);
        @(posedge clk);
        #1;
        chk("bp_idle_q", 16'({bus.out_valid, bus.quotient}), 16'({1'b0, 4'b0010}));

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 4'b0111;
        bus.b = 4'b0011;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_state", 16'({bus.in_ready, bus.out_valid}), 16'b10);
        chk("arst_outs", 16'({bus.quotient, bus.remainder, bus.div_by_zero}), 16'h0);
        @(posedge clk);
        #1;
        chk("arst_no_result", 16'(bus.out_valid), 16'h0);
        @(negedge clk) rst_n = 1'b1;
        do_op(4'b0110, 4'b0010, q, r, dz, lat);
        chk("post_rst_lat", 16'(lat), 16'd3);
        chk("post_rst_qr", 16'({dz, q, r}), 16'({1'b0, 4'b0011, 4'b0000}));

        for (int i = 0; i < 256; i++) begin
            logic [7:0] ab;
            ab = 8'(i);
            exp9 = ref_div(ab[7:4], ab[3:0]);
            do_op(ab[7:4], ab[3:0], q, r, dz, lat);
            chk($sformatf("sweep_%02h", ab), 16'({dz, q, r}), 16'(exp9));
            chk($sformatf("sweep_lat_%02h", ab), 16'(lat),
                (ab[2:0] == 3'd0) ? 16'd1 : 16'd3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
